// File: rtl/uno_pkg.sv
// Shared types for the UNO game datapath: card layout, value codes,
// scheduler states and seat arithmetic.
package uno_pkg;

  typedef enum logic [1:0] {
    COL_RED    = 2'b00,
    COL_YELLOW = 2'b01,
    COL_GREEN  = 2'b10,
    COL_BLUE   = 2'b11
  } colour_e;

  localparam logic [3:0] VAL_SKIP  = 4'hA;
  localparam logic [3:0] VAL_REV   = 4'hB;
  localparam logic [3:0] VAL_DRAW2 = 4'hC;
  localparam logic [3:0] VAL_WILD  = 4'hD;
  localparam logic [3:0] VAL_WILD4 = 4'hE;

  typedef struct packed {
    colour_e    colour;
    logic [3:0] value;
  } card_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DEAL,
    ST_FLIP,
    ST_TURN,
    ST_RESOLVE,
    ST_ADVANCE,
    ST_WIN
  } state_e;

  typedef enum logic [1:0] {
    PEND_NONE,
    PEND_D2,
    PEND_D4
  } pend_e;

  function automatic logic card_is_wild(input logic [3:0] value);
    return (value == VAL_WILD) || (value == VAL_WILD4);
  endfunction

  // Seat after moving 'step' places in direction 'dir' around a table of n seats.
  function automatic logic [1:0] next_seat(input logic [1:0] turn,
                                           input logic [1:0] step,
                                           input logic       dir,
                                           input logic [2:0] n);
    logic [2:0] t;
    logic [2:0] s;
    logic [2:0] r;
    t = {1'b0, turn};
    s = {1'b0, step};
    if (!dir) begin
      r = t + s;
      if (r >= n) r = r - n;
    end else begin
      if (t >= s) r = t - s;
      else        r = t + n - s;
    end
    return 2'(r);
  endfunction

endpackage

// File: rtl/uno_card_decode.sv
// Combinational decode of a card value into its effect on turn order.
// Also used by the Computer block to rank candidate plays.
module uno_card_decode
  import uno_pkg::*;
#(
  parameter int NPLAYER = 4
) (
  input  logic [3:0] value_i,
  output logic [1:0] step_o,
  output logic       rev_o,
  output logic       pend_d2_o,
  output logic       pend_d4_o,
  output logic       is_wild_o
);

  always_comb begin
    step_o    = 2'd1;
    rev_o     = 1'b0;
    pend_d2_o = 1'b0;
    pend_d4_o = 1'b0;
    is_wild_o = card_is_wild(value_i);
    case (value_i)
      VAL_SKIP:  step_o = 2'd2;
      VAL_REV: begin
        rev_o  = 1'b1;
        // two seats: a reverse hands the turn straight back, like a skip
        step_o = (NPLAYER == 2) ? 2'd2 : 2'd1;
      end
      VAL_DRAW2: pend_d2_o = 1'b1;
      VAL_WILD4: pend_d4_o = 1'b1;
      default:   ;
    endcase
  end

endmodule

// File: rtl/uno_turn_scheduler.sv
// Game sequencer: deals hands, flips the opening discard, grants turns,
// applies card effects and reports the winner.
//
// state      | meaning
// -----------+---------------------------------------------------------
// ST_IDLE    | waiting for a new game
// ST_DEAL    | routing HAND_INIT deck cards to each seat in turn
// ST_FLIP    | drawing the opening discard, redrawing over wilds
// ST_TURN    | seat o_turn holds the grant
// ST_RESOLVE | decode the played card or detect an empty hand
// ST_ADVANCE | move the grant by step in the current direction
// ST_WIN     | game over, winner held until a new game
module uno_turn_scheduler
  import uno_pkg::*;
#(
  parameter int NPLAYER   = 4,
  parameter int HAND_INIT = 7
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_new_game,
  output logic [NPLAYER-1:0]     o_init,
  output logic [NPLAYER-1:0]     o_start,
  output logic [NPLAYER-1:0]     o_draw_two,
  output logic [NPLAYER-1:0]     o_draw_four,
  output logic [5:0]             o_prev_card,
  input  logic [NPLAYER-1:0]     i_out,
  input  logic [6*NPLAYER-1:0]   i_out_card,
  input  logic [NPLAYER-1:0]     i_draw,
  input  logic [NPLAYER-1:0]     i_empty,
  output logic [1:0]             o_deck_sel,
  output logic                   o_deck_req,
  input  logic                   i_drawn,
  input  logic [5:0]             i_drawed_card,
  output logic [1:0]             o_turn,
  output logic                   o_dir,
  output logic                   o_winner_vld,
  output logic [1:0]             o_winner
);

  localparam int         CNT_W    = $clog2(HAND_INIT + 1);
  localparam logic [2:0] NSEAT    = 3'(NPLAYER);
  localparam logic [1:0] LAST_SEAT = 2'(NPLAYER - 1);

  state_e           state_q,  state_d;
  logic [1:0]       turn_q,   turn_d;
  logic             dir_q,    dir_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  card_t            prev_q,   prev_d;
  logic [1:0]       step_q,   step_d;
  pend_e            pend_q,   pend_d;
  logic             first_q,  first_d;
  logic             init_q,   init_d;
  logic             gap_q,    gap_d;
  logic [1:0]       winner_q, winner_d;

  logic [3:0] dec_value;
  logic [1:0] dec_step;
  logic       dec_rev;
  logic       dec_d2;
  logic       dec_d4;
  logic       dec_wild;

  // FLIP inspects the incoming deck card; RESOLVE inspects the card just played.
  assign dec_value = (state_q == ST_FLIP) ? i_drawed_card[3:0] : prev_q.value;

  uno_card_decode #(
    .NPLAYER (NPLAYER)
  ) u_decode (
    .value_i   (dec_value),
    .step_o    (dec_step),
    .rev_o     (dec_rev),
    .pend_d2_o (dec_d2),
    .pend_d4_o (dec_d4),
    .is_wild_o (dec_wild)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= ST_IDLE;
      turn_q   <= 2'd0;
      dir_q    <= 1'b0;
      cnt_q    <= '0;
      prev_q   <= '0;
      step_q   <= 2'd0;
      pend_q   <= PEND_NONE;
      first_q  <= 1'b0;
      init_q   <= 1'b0;
      gap_q    <= 1'b0;
      winner_q <= 2'd0;
    end else begin
      state_q  <= state_d;
      turn_q   <= turn_d;
      dir_q    <= dir_d;
      cnt_q    <= cnt_d;
      prev_q   <= prev_d;
      step_q   <= step_d;
      pend_q   <= pend_d;
      first_q  <= first_d;
      init_q   <= init_d;
      gap_q    <= gap_d;
      winner_q <= winner_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    turn_d   = turn_q;
    dir_d    = dir_q;
    cnt_d    = cnt_q;
    prev_d   = prev_q;
    step_d   = step_q;
    pend_d   = pend_q;
    first_d  = 1'b0;
    init_d   = 1'b0;
    gap_d    = 1'b0;
    winner_d = winner_q;

    o_init       = '0;
    o_start      = '0;
    o_draw_two   = '0;
    o_draw_four  = '0;
    o_prev_card  = prev_q;
    o_deck_sel   = turn_q;
    o_deck_req   = 1'b0;
    o_turn       = turn_q;
    o_dir        = dir_q;
    o_winner_vld = 1'b0;
    o_winner     = 2'd0;

    case (state_q)
      ST_IDLE: begin
        if (i_new_game) begin
          state_d = ST_DEAL;
          turn_d  = 2'd0;
          cnt_d   = CNT_W'(HAND_INIT);
          init_d  = 1'b1;
        end
      end

      ST_DEAL: begin
        o_init[turn_q] = init_q;
        if (i_drawn) begin
          if (cnt_q == CNT_W'(1)) begin
            if (turn_q == LAST_SEAT) begin
              state_d = ST_FLIP;
              turn_d  = 2'd0;
            end else begin
              turn_d = turn_q + 2'd1;
              cnt_d  = CNT_W'(HAND_INIT);
              init_d = 1'b1;
            end
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end

      ST_FLIP: begin
        // After a wild the request drops for a cycle so the deck sees a fresh request.
        o_deck_req = !gap_q;
        if (i_drawn) begin
          prev_d = card_t'(i_drawed_card);
          if (dec_wild) begin
            gap_d = 1'b1;
          end else begin
            state_d = ST_TURN;
            turn_d  = 2'd0;
            dir_d   = 1'b0;
            pend_d  = PEND_NONE;
            first_d = 1'b1;
          end
        end
      end

      ST_TURN: begin
        o_start[turn_q] = 1'b1;
        if (first_q) begin
          o_draw_two[turn_q]  = (pend_q == PEND_D2);
          o_draw_four[turn_q] = (pend_q == PEND_D4);
          pend_d              = PEND_NONE;
        end
        if (i_out[turn_q]) begin
          prev_d  = card_t'(i_out_card[turn_q*6 +: 6]);
          state_d = ST_RESOLVE;
        end else if (i_draw[turn_q]) begin
          step_d  = 2'd1;
          state_d = ST_ADVANCE;
        end
      end

      ST_RESOLVE: begin
        if (i_empty[turn_q]) begin
          winner_d = turn_q;
          state_d  = ST_WIN;
        end else begin
          step_d  = dec_step;
          state_d = ST_ADVANCE;
          if (dec_rev) dir_d  = !dir_q;
          if (dec_d2)  pend_d = PEND_D2;
          if (dec_d4)  pend_d = PEND_D4;
        end
      end

      ST_ADVANCE: begin
        turn_d  = next_seat(turn_q, step_q, dir_q, NSEAT);
        first_d = 1'b1;
        state_d = ST_TURN;
      end

      ST_WIN: begin
        o_winner_vld = 1'b1;
        o_winner     = winner_q;
        if (i_new_game) begin
          state_d = ST_DEAL;
          turn_d  = 2'd0;
          cnt_d   = CNT_W'(HAND_INIT);
          init_d  = 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_uno_turn_scheduler.sv
// Directed bench for uno_turn_scheduler: deal, flip, card effects, win and reset.
module tb_uno_turn_scheduler;

  localparam int NPLAYER   = 4;
  localparam int HAND_INIT = 7;

  logic                 clk;
  logic                 rst;
  logic                 new_game;
  logic [NPLAYER-1:0]   init;
  logic [NPLAYER-1:0]   start;
  logic [NPLAYER-1:0]   draw_two;
  logic [NPLAYER-1:0]   draw_four;
  logic [5:0]           prev_card;
  logic [NPLAYER-1:0]   out;
  logic [6*NPLAYER-1:0] out_card;
  logic [NPLAYER-1:0]   draw;
  logic [NPLAYER-1:0]   empty;
  logic [1:0]           deck_sel;
  logic                 deck_req;
  logic                 drawn;
  logic [5:0]           drawed_card;
  logic [1:0]           turn;
  logic                 dir;
  logic                 winner_vld;
  logic [1:0]           winner;

  int n_checks = 0;
  int n_fail   = 0;

  uno_turn_scheduler #(
    .NPLAYER   (NPLAYER),
    .HAND_INIT (HAND_INIT)
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_new_game    (new_game),
    .o_init        (init),
    .o_start       (start),
    .o_draw_two    (draw_two),
    .o_draw_four   (draw_four),
    .o_prev_card   (prev_card),
    .i_out         (out),
    .i_out_card    (out_card),
    .i_draw        (draw),
    .i_empty       (empty),
    .o_deck_sel    (deck_sel),
    .o_deck_req    (deck_req),
    .i_drawn       (drawn),
    .i_drawed_card (drawed_card),
    .o_turn        (turn),
    .o_dir         (dir),
    .o_winner_vld  (winner_vld),
    .o_winner      (winner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Seat plays a card; optionally also raises i_draw in the same cycle.
  task automatic play(input int seat, input logic [5:0] card, input logic also_draw);
    out[seat]             = 1'b1;
    out_card[seat*6 +: 6] = card;
    draw[seat]            = also_draw;
    tick();
    out  = '0;
    draw = '0;
  endtask

  task automatic vol_draw(input int seat);
    draw[seat] = 1'b1;
    tick();
    draw = '0;
  endtask

  initial begin
    rst         = 1'b1;
    new_game    = 1'b0;
    out         = '0;
    out_card    = '0;
    draw        = '0;
    empty       = '0;
    drawn       = 1'b0;
    drawed_card = '0;
    tick();
    tick();
    rst = 1'b0;

    check_eq("rst_start",  32'(start),      32'h0);
    check_eq("rst_init",   32'(init),       32'h0);
    check_eq("rst_prev",   32'(prev_card),  32'h0);
    check_eq("rst_req",    32'(deck_req),   32'h0);
    check_eq("rst_turn",   32'(turn),       32'h0);
    check_eq("rst_dir",    32'(dir),        32'h0);
    check_eq("rst_winvld", 32'(winner_vld), 32'h0);

    // deal: 7 cards to each of 4 seats, one card per cycle
    new_game = 1'b1;
    tick();
    new_game = 1'b0;
    for (int s = 0; s < NPLAYER; s++) begin
      for (int k = 0; k < HAND_INIT; k++) begin
        if (k == 0) begin
          check_eq($sformatf("deal_init_s%0d", s), 32'(init), 32'(1 << s));
          check_eq($sformatf("deal_sel_s%0d", s), 32'(deck_sel), 32'(s));
        end
        if (s == 0 && k == 1) check_eq("deal_init_pulse", 32'(init), 32'h0);
        drawn = 1'b1;
        tick();
      end
    end
    drawn = 1'b0;
    check_eq("flip_req",   32'(deck_req), 32'h1);
    check_eq("flip_start", 32'(start),    32'h0);

    // wild flip is latched, then re-requested after a one-cycle gap
    drawed_card = 6'b111101;
    drawn       = 1'b1;
    tick();
    drawn = 1'b0;
    check_eq("flip_wild_gap",  32'(deck_req),  32'h0);
    check_eq("flip_wild_prev", 32'(prev_card), 32'h3D);
    tick();
    check_eq("flip_rereq", 32'(deck_req), 32'h1);
    drawed_card = 6'b001000;
    drawn       = 1'b1;
    tick();
    drawn = 1'b0;
    check_eq("flip_prev",  32'(prev_card), 32'h08);
    check_eq("turn0_start", 32'(start),    32'h1);
    check_eq("turn0_turn",  32'(turn),     32'h0);
    check_eq("turn0_d2",    32'(draw_two), 32'h0);
    check_eq("turn0_d4",    32'(draw_four), 32'h0);

    // off-turn play/draw and a mid-game new_game are all ignored
    out[3]          = 1'b1;
    out_card[23:18] = 6'b000101;
    draw[2]         = 1'b1;
    new_game        = 1'b1;
    tick();
    out      = '0;
    draw     = '0;
    new_game = 1'b0;
    check_eq("noise_start", 32'(start),     32'h1);
    check_eq("noise_prev",  32'(prev_card), 32'h08);

    // skip: seat 0 -> seat 2, two-cycle gap
    play(0, 6'b001010, 1'b0);
    check_eq("skip_prev",   32'(prev_card), 32'h0A);
    check_eq("skip_gap1",   32'(start),     32'h0);
    tick();
    check_eq("skip_gap2",   32'(start),     32'h0);
    tick();
    check_eq("skip_start",  32'(start),     32'h4);
    check_eq("skip_turn",   32'(turn),      32'h2);

    // plain number: seat 2 -> seat 3
    play(2, 6'b010101, 1'b0);
    tick();
    tick();
    check_eq("num_start", 32'(start), 32'h8);

    // voluntary draw wraps 3 -> 0 with a one-cycle gap
    vol_draw(3);
    check_eq("draw_gap",   32'(start), 32'h0);
    tick();
    check_eq("draw_wrap",  32'(start), 32'h1);
    vol_draw(0);
    tick();
    check_eq("draw_s1", 32'(start), 32'h2);

    // wild draw four: seat 1 -> seat 2 with one D4 pulse
    play(1, 6'b011110, 1'b0);
    tick();
    tick();
    check_eq("d4_start", 32'(start),     32'h4);
    check_eq("d4_pulse", 32'(draw_four), 32'h4);
    check_eq("d4_no_d2", 32'(draw_two),  32'h0);
    tick();
    check_eq("d4_once",  32'(draw_four), 32'h0);
    check_eq("d4_hold",  32'(start),     32'h4);

    // draw two played with i_draw also high: the play wins
    play(2, 6'b101100, 1'b1);
    check_eq("both_prev", 32'(prev_card), 32'h2C);
    tick();
    tick();
    check_eq("d2_start",  32'(start),     32'h8);
    check_eq("d2_pulse",  32'(draw_two),  32'h8);
    check_eq("d2_no_d4",  32'(draw_four), 32'h0);
    tick();
    check_eq("d2_once",   32'(draw_two),  32'h0);

    vol_draw(3);
    tick();
    check_eq("nopen_start", 32'(start),    32'h1);
    check_eq("nopen_d2",    32'(draw_two), 32'h0);

    // reverse: seat 0 -> seat 3 descending
    play(0, 6'b111011, 1'b0);
    tick();
    tick();
    check_eq("rev_dir",   32'(dir),   32'h1);
    check_eq("rev_turn",  32'(turn),  32'h3);
    check_eq("rev_start", 32'(start), 32'h8);
    vol_draw(3);
    tick();
    check_eq("desc_start", 32'(start), 32'h4);

    // seat 2 plays its last card
    empty[2] = 1'b1;
    play(2, 6'b100111, 1'b0);
    tick();
    check_eq("win_vld",   32'(winner_vld), 32'h1);
    check_eq("win_seat",  32'(winner),     32'h2);
    check_eq("win_start", 32'(start),      32'h0);
    tick();
    check_eq("win_hold",  32'(winner_vld), 32'h1);
    empty = '0;

    // new game from WIN goes straight to dealing
    new_game = 1'b1;
    tick();
    new_game = 1'b0;
    check_eq("ng_vld",  32'(winner_vld), 32'h0);
    check_eq("ng_init", 32'(init),       32'h1);
    for (int k = 0; k < HAND_INIT + 2; k++) begin
      drawn = 1'b1;
      tick();
    end
    check_eq("middeal_turn", 32'(turn), 32'h1);

    // reset mid-deal, with a card still arriving
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("mrst_init",  32'(init),       32'h0);
    check_eq("mrst_turn",  32'(turn),       32'h0);
    check_eq("mrst_dir",   32'(dir),        32'h0);
    check_eq("mrst_prev",  32'(prev_card),  32'h0);
    check_eq("mrst_sel",   32'(deck_sel),   32'h0);
    check_eq("mrst_req",   32'(deck_req),   32'h0);
    check_eq("mrst_start", 32'(start),      32'h0);
    check_eq("mrst_vld",   32'(winner_vld), 32'h0);
    tick();
    tick();
    drawn = 1'b0;
    check_eq("idle_turn", 32'(turn), 32'h0);
    check_eq("idle_init", 32'(init), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
